// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and constants for the per-channel clock-gating controller.
package clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_ON   = 2'b00,
    ST_IDLE = 2'b01,
    ST_OFF  = 2'b10,
    ST_WAKE = 2'b11
  } state_t;

  localparam int IDLE_CYC_DEF = 8;
  localparam int WAKE_CYC_DEF = 2;
  localparam int STAT_W       = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// Activity/wake/gate-cell bundle between monitors and the gating controller.
// CLK_GATE_STATS_EN adds the per-channel gated-cycle counters (gcnt).
interface clk_gate_ctrl_if
  import clk_gate_ctrl_pkg::*;
#(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] busy;
  logic [N_CH-1:0] wreq;
  logic [N_CH-1:0] wack;
  logic [N_CH-1:0] en;
  logic [N_CH-1:0] se;
  logic [N_CH-1:0] gated;
  logic            te;
  logic            force_on;
`ifdef CLK_GATE_STATS_EN
  logic [N_CH*STAT_W-1:0] gcnt;

  modport master (output busy, wreq, te, force_on,
                  input  wack, en, se, gated, gcnt);
  modport slave  (input  busy, wreq, te, force_on,
                  output wack, en, se, gated, gcnt);
`else
  modport master (output busy, wreq, te, force_on,
                  input  wack, en, se, gated);
  modport slave  (input  busy, wreq, te, force_on,
                  output wack, en, se, gated);
`endif
endinterface

// File: rtl/clk_gate_ctrl_ch.sv
// Single-channel gating FSM: idle hold-off, wake settle, 4-phase WACK.
// CLK_GATE_STATS_EN adds a saturating count of cycles spent gated.
module clk_gate_ch
  import clk_gate_ctrl_pkg::*;
#(
  parameter int IDLE_CYC = IDLE_CYC_DEF,
  parameter int WAKE_CYC = WAKE_CYC_DEF,
  parameter int CNT_W    = 4
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              busy,
  input  logic              wreq,
  input  logic              force_on,
  output logic              en,
  output logic              gated,
`ifdef CLK_GATE_STATS_EN
  output logic [STAT_W-1:0] gcnt,
`endif
  output logic              wack
);

  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYC - 1);
  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             wack_q;

  // WACK is set only on edges whose next state is ON, mirroring the branch taken.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state  <= ST_ON;
      cnt    <= '0;
      wack_q <= 1'b0;
    end else if (force_on) begin
      state  <= ST_ON;
      cnt    <= '0;
      wack_q <= wreq;
    end else begin
      wack_q <= 1'b0;
      case (state)
        ST_ON: begin
          if (!busy && !wreq) begin
            state <= ST_IDLE;
            cnt   <= IDLE_LD;
          end else begin
            wack_q <= wreq;
          end
        end
        ST_IDLE: begin
          if (busy || wreq) begin
            state  <= ST_ON;
            wack_q <= wreq;
          end else if (cnt == '0) begin
            state <= ST_OFF;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_OFF: begin
          if (busy || wreq) begin
            state <= ST_WAKE;
            cnt   <= WAKE_LD;
          end
        end
        ST_WAKE: begin
          if (cnt == '0) begin
            state  <= ST_ON;
            wack_q <= wreq;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_ON;
      endcase
    end
  end

  // Cell enables decode straight from the state flops: no input reaches EN combinationally.
  assign en    = (state != ST_OFF);
  assign gated = (state == ST_OFF);
  assign wack  = wack_q;

`ifdef CLK_GATE_STATS_EN
  logic [STAT_W-1:0] stat_q;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      stat_q <= '0;
    end else if (state == ST_OFF) begin
      stat_q <= sat_inc(stat_q);
    end
  end

  assign gcnt = stat_q;
`endif

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gating controller top: one clk_gate_ch per CLKGATETST cell, SE = TE.
// CLK_GATE_STATS_EN exposes per-channel gated-cycle counters on bus.gcnt.
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int IDLE_CYC = IDLE_CYC_DEF,
  parameter int WAKE_CYC = WAKE_CYC_DEF,
  parameter int CNT_W    = 4
) (
  input  logic           ck,
  input  logic           rst,
  clk_gate_ctrl_if.slave bus
);

  logic [N_CH-1:0] en_v;
  logic [N_CH-1:0] gated_v;
  logic [N_CH-1:0] wack_v;
`ifdef CLK_GATE_STATS_EN
  logic [N_CH*STAT_W-1:0] gcnt_v;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    clk_gate_ch #(
      .IDLE_CYC (IDLE_CYC),
      .WAKE_CYC (WAKE_CYC),
      .CNT_W    (CNT_W)
    ) u_ch (
      .ck       (ck),
      .rst      (rst),
      .busy     (bus.busy[i]),
      .wreq     (bus.wreq[i]),
      .force_on (bus.force_on),
      .en       (en_v[i]),
      .gated    (gated_v[i]),
`ifdef CLK_GATE_STATS_EN
      .gcnt     (gcnt_v[i*STAT_W +: STAT_W]),
`endif
      .wack     (wack_v[i])
    );
  end

  assign bus.en    = en_v;
  assign bus.gated = gated_v;
  assign bus.wack  = wack_v;
  assign bus.se    = {N_CH{bus.te}};
`ifdef CLK_GATE_STATS_EN
  assign bus.gcnt  = gcnt_v;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: quiet-run-length reference model checked every cycle,
// plus directed literal checks. CLK_GATE_STATS_EN enables the saturation test.
module tb_clk_gate_ctrl;

  localparam int N   = 4;
  localparam int IDL = 8;
  localparam int WKC = 2;

  localparam int M_RUN  = 0;
  localparam int M_OFF  = 1;
  localparam int M_WAKE = 2;

  logic ck = 1'b0;
  logic rst;

  int n_chk  = 0;
  int n_fail = 0;

  clk_gate_ctrl_if #(.N_CH(N)) bus ();

  clk_gate_ctrl #(
    .N_CH     (N),
    .IDLE_CYC (IDL),
    .WAKE_CYC (WKC),
    .CNT_W    (4)
  ) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  always #5 ck = ~ck;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a channel is running, gated, or waking. Running channels gate
  // once they have seen more than IDL consecutive quiet samples.
  typedef struct {
    int          mode;
    int          run;
    int          left;
    bit          wack;
    int unsigned stat;
  } mch_t;

  function automatic mch_t mreset();
    mch_t s;
    s.mode = M_RUN; s.run = 0; s.left = 0; s.wack = 1'b0; s.stat = 0;
    return s;
  endfunction

  function automatic mch_t mstep(mch_t s, bit b, bit r, bit f);
    mch_t n = s;
    bit quiet = !b && !r;
    if (s.mode == M_OFF && n.stat < 65535) n.stat = s.stat + 1;
    n.wack = 1'b0;
    if (f) begin
      n.mode = M_RUN; n.run = 0; n.wack = r;
      return n;
    end
    if (s.mode == M_RUN) begin
      n.run = quiet ? s.run + 1 : 0;
      if (n.run > IDL) begin
        n.mode = M_OFF; n.run = 0;
      end else begin
        n.wack = r;
      end
    end else if (s.mode == M_OFF) begin
      if (!quiet) begin
        n.mode = M_WAKE; n.left = WKC;
      end
    end else begin
      n.left = s.left - 1;
      if (n.left == 0) begin
        n.mode = M_RUN; n.run = 0; n.wack = r;
      end
    end
    return n;
  endfunction

  mch_t m[N];

  always @(posedge ck or posedge rst) begin
    for (int i = 0; i < N; i++) begin
      if (rst) m[i] <= mreset();
      else     m[i] <= mstep(m[i], bus.busy[i], bus.wreq[i], bus.force_on);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge ck) begin
    if (rst !== 1'bx) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("model_en[%0d]", i),    64'(bus.en[i]),    64'(m[i].mode != M_OFF));
        chk($sformatf("model_gated[%0d]", i), 64'(bus.gated[i]), 64'(m[i].mode == M_OFF));
        chk($sformatf("model_wack[%0d]", i),  64'(bus.wack[i]),  64'(m[i].wack));
`ifdef CLK_GATE_STATS_EN
        chk($sformatf("model_gcnt[%0d]", i),  64'(bus.gcnt[i*16 +: 16]), 64'(m[i].stat));
`endif
      end
      chk("model_se", 64'(bus.se), 64'({N{bus.te}}));
    end
  end

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.busy     = 4'hF;
    bus.wreq     = 4'h0;
    bus.te       = 1'b0;
    bus.force_on = 1'b0;
    repeat (3) @(posedge ck);
    #1;
    chk("rst_en",    64'(bus.en),    64'h F);
    chk("rst_gated", 64'(bus.gated), 64'h0);
    chk("rst_wack",  64'(bus.wack),  64'h0);
    rst = 1'b0;
    tick(); tick();

    // Idle gating on channel 0: next edge is edge 0.
    bus.busy = 4'b1110;
    repeat (8) tick();
    chk("idle_en0_edge7", 64'(bus.en[0]), 64'h1);
    tick();
    chk("idle_en0_edge8",    64'(bus.en[0]),    64'h0);
    chk("idle_gated0_edge8", 64'(bus.gated[0]), 64'h1);

    // Hold-off restart on channel 1: busy pulse when count is 3.
    bus.busy = 4'b1100;
    repeat (5) tick();
    bus.busy = 4'b1110;
    tick();
    bus.busy = 4'b1100;
    repeat (8) tick();
    chk("holdoff_en1_p8", 64'(bus.en[1]), 64'h1);
    tick();
    chk("holdoff_en1_p9", 64'(bus.en[1]), 64'h0);

    // Wake handshake on channel 2.
    bus.busy = 4'b1000;
    repeat (10) tick();
    chk("wake_pre_gated2", 64'(bus.gated[2]), 64'h1);
    bus.wreq = 4'b0100;
    tick();
    chk("wake_en2_w",    64'(bus.en[2]),   64'h1);
    chk("wake_wack2_w",  64'(bus.wack[2]), 64'h0);
    tick();
    chk("wake_wack2_w1", 64'(bus.wack[2]), 64'h0);
    tick();
    chk("wake_wack2_w2",  64'(bus.wack[2]),  64'h1);
    chk("wake_gated2_w2", 64'(bus.gated[2]), 64'h0);
    bus.wreq = 4'b0000;
    tick();
    chk("wake_wack2_drop", 64'(bus.wack[2]), 64'h0);

    // Wake request while running: acknowledged one cycle later.
    bus.wreq = 4'b1000;
    tick();
    chk("on_wack3", 64'(bus.wack[3]), 64'h1);
    bus.wreq = 4'b0000;
    tick();
    chk("on_wack3_drop", 64'(bus.wack[3]), 64'h0);

    // Busy falls as wreq rises: channel stays on.
    bus.busy = 4'b0000;
    bus.wreq = 4'b1000;
    tick();
    chk("swap_en3",   64'(bus.en[3]),   64'h1);
    chk("swap_wack3", 64'(bus.wack[3]), 64'h1);
    repeat (12) tick();
    chk("swap_hold_en3", 64'(bus.en[3]), 64'h1);
    bus.wreq = 4'b0000;
    tick();
    chk("swap_wack3_drop", 64'(bus.wack[3]), 64'h0);
    repeat (10) tick();
    chk("all_gated", 64'(bus.gated), 64'hF);

    // Asynchronous reset mid-cycle with channels gated.
    @(posedge ck);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_en",    64'(bus.en),    64'hF);
    chk("async_rst_gated", 64'(bus.gated), 64'h0);
    chk("async_rst_wack",  64'(bus.wack),  64'h0);
    @(posedge ck);
    #1;
    rst = 1'b0;

    // FORCE_ON override.
    repeat (10) tick();
    chk("force_pre_gated", 64'(bus.gated), 64'hF);
    bus.force_on = 1'b1;
    tick();
    chk("force_en", 64'(bus.en), 64'hF);
    repeat (20) tick();
    chk("force_hold_gated", 64'(bus.gated), 64'h0);
    bus.wreq = 4'b0001;
    tick();
    chk("force_wack0", 64'(bus.wack[0]), 64'h1);
    bus.wreq = 4'b0000;
    tick();
    chk("force_wack0_drop", 64'(bus.wack[0]), 64'h0);
    bus.force_on = 1'b0;
    repeat (8) tick();
    chk("release_en0_edge7", 64'(bus.en[0]), 64'h1);
    tick();
    chk("release_en0_edge8", 64'(bus.en[0]), 64'h0);

    // Test enable only touches SE.
    bus.te = 1'b1;
    #1;
    chk("te_se", 64'(bus.se), 64'hF);
    chk("te_en", 64'(bus.en), 64'h0);
    tick();
    bus.te = 1'b0;
    #1;
    chk("te_se_off", 64'(bus.se), 64'h0);

`ifdef CLK_GATE_STATS_EN
    repeat (70000) tick();
    chk("gcnt3_sat", 64'(bus.gcnt[63:48]), 64'hFFFF);
    chk("gcnt0_sat", 64'(bus.gcnt[15:0]),  64'hFFFF);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
